// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } if_state_e;

  localparam logic [1:0] JMP_SEQ = 2'b00;
  localparam logic [1:0] JMP_J   = 2'b01;
  localparam logic [1:0] JMP_JR  = 2'b10;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] order;
    logic [31:0] pcadd4;
    logic        valid;
  } ifid_t;

  // Sequential successor; wraps modulo 2^32 by construction.
  function automatic logic [31:0] pc_add4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_next_pc.sv
// Redirect priority mux: register jumps, then j/jal, then taken branch.
module if_next_pc
  import if_pkg::*;
(
  input  logic [1:0]  jump_i,
  input  logic [1:0]  rjump_i,
  input  logic        pcsrc_i,
  input  logic [31:0] baddr_i,
  input  logic [31:0] jaddr_i,
  input  logic [31:0] jraddr_i,
  output logic        redir_o,
  output logic [31:0] target_o
);

  always_comb begin
    redir_o  = 1'b0;
    target_o = baddr_i;
    if (rjump_i != 2'b00) begin
      redir_o  = 1'b1;
      target_o = jraddr_i;
    end else begin
      case (jump_i)
        JMP_JR: begin
          redir_o  = 1'b1;
          target_o = jraddr_i;
        end
        JMP_J: begin
          redir_o  = 1'b1;
          target_o = jaddr_i;
        end
        JMP_SEQ: begin
          redir_o  = pcsrc_i;
          target_o = baddr_i;
        end
        // reserved encoding behaves as sequential
        default: begin
          redir_o  = pcsrc_i;
          target_o = baddr_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, req/ack fetch FSM, redirect pend, hold and IF/ID registers.
// Define IFID_FLUSH_EN to squash the word fetched alongside a redirect instead of keeping a delay slot.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        IF_inPCWRITE,
  input  logic        IF_inIFIDWRITE,
  input  logic        IF_inpcsrc,
  input  logic [31:0] IF_inbaddress,
  input  logic [1:0]  IF_injump,
  input  logic [31:0] IF_injumpaddress,
  input  logic [1:0]  IF_inrjump,
  input  logic [31:0] IF_injraddress,
  output logic        IMEM_req,
  output logic [31:0] IMEM_addr,
  input  logic        IMEM_ack,
  input  logic [31:0] IMEM_rdata,
  output logic [31:0] IFID_ORDER,
  output logic [31:0] IFID_PCADD4,
  output logic        IFID_VALID,
  output logic [31:0] IF_outPC
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] hold_q, hold_d;
  ifid_t       ifid_q, ifid_d;

  logic        load;
  logic        redir;
  logic        redir_live;
  logic        deliver;
  logic        squash;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic [31:0] fetch_word;

  if_next_pc u_next_pc (
    .jump_i   (IF_injump),
    .rjump_i  (IF_inrjump),
    .pcsrc_i  (IF_inpcsrc),
    .baddr_i  (IF_inbaddress),
    .jaddr_i  (IF_injumpaddress),
    .jraddr_i (IF_injraddress),
    .redir_o  (redir),
    .target_o (target)
  );

  // A mismatched PCWRITE/IFIDWRITE pair is treated as a stall.
  assign load       = IF_inIFIDWRITE & IF_inPCWRITE;
  assign redir_live = redir & ifid_q.valid & IF_inPCWRITE;
  assign pc_plus4   = pc_add4(pc_q);
  assign fetch_word = (state_q == HOLD) ? hold_q : IMEM_rdata;
  assign deliver    = load & (((state_q == REQ) & IMEM_ack) | (state_q == HOLD));

`ifdef IFID_FLUSH_EN
  assign squash = redir_live | pend_vld_q;
`else
  assign squash = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    hold_d     = hold_q;
    ifid_d     = ifid_q;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (IMEM_ack && !load) begin
          hold_d  = IMEM_rdata;
          state_d = HOLD;
        end
      end
      HOLD:    state_d = HOLD;
      default: state_d = IDLE;
    endcase

    if (deliver) begin
      ifid_d.order  = squash ? NOP_WORD : fetch_word;
      ifid_d.pcadd4 = pc_plus4;
      ifid_d.valid  = ~squash;
      pc_d          = redir_live ? target : (pend_vld_q ? pend_tgt_q : pc_plus4);
      pend_vld_d    = 1'b0;
      state_d       = REQ;
    end else if (redir_live) begin
      // remember the redirect until the next word is actually delivered
      pend_vld_d = 1'b1;
      pend_tgt_d = target;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      pend_vld_q    <= 1'b0;
      pend_tgt_q    <= 32'h0;
      hold_q        <= 32'h0;
      ifid_q.order  <= NOP_WORD;
      ifid_q.pcadd4 <= 32'h0;
      ifid_q.valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
      hold_q     <= hold_d;
      ifid_q     <= ifid_d;
    end
  end

  assign IMEM_req    = (state_q == REQ);
  assign IMEM_addr   = pc_q;
  assign IFID_ORDER  = ifid_q.order;
  assign IFID_PCADD4 = ifid_q.pcadd4;
  assign IFID_VALID  = ifid_q.valid;
  assign IF_outPC    = pc_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; expectations follow IFID_FLUSH_EN when it is defined.
module tb_if_fetch_stage;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        IF_inPCWRITE;
  logic        IF_inIFIDWRITE;
  logic        IF_inpcsrc;
  logic [31:0] IF_inbaddress;
  logic [1:0]  IF_injump;
  logic [31:0] IF_injumpaddress;
  logic [1:0]  IF_inrjump;
  logic [31:0] IF_injraddress;
  logic        IMEM_req;
  logic [31:0] IMEM_addr;
  logic        IMEM_ack;
  logic [31:0] IMEM_rdata;
  logic [31:0] IFID_ORDER;
  logic [31:0] IFID_PCADD4;
  logic        IFID_VALID;
  logic [31:0] IF_outPC;

  localparam logic [31:0] BAD = 32'hDEAD_BEEF;
  localparam logic [31:0] NOP = 32'h0000_0000;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  logic [31:0] cur_order;
  logic        cur_valid;

  if_fetch_stage dut (
    .CLOCK            (CLOCK),
    .RESET            (RESET),
    .IF_inPCWRITE     (IF_inPCWRITE),
    .IF_inIFIDWRITE   (IF_inIFIDWRITE),
    .IF_inpcsrc       (IF_inpcsrc),
    .IF_inbaddress    (IF_inbaddress),
    .IF_injump        (IF_injump),
    .IF_injumpaddress (IF_injumpaddress),
    .IF_inrjump       (IF_inrjump),
    .IF_injraddress   (IF_injraddress),
    .IMEM_req         (IMEM_req),
    .IMEM_addr        (IMEM_addr),
    .IMEM_ack         (IMEM_ack),
    .IMEM_rdata       (IMEM_rdata),
    .IFID_ORDER       (IFID_ORDER),
    .IFID_PCADD4      (IFID_PCADD4),
    .IFID_VALID       (IFID_VALID),
    .IF_outPC         (IF_outPC)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_redirect();
    IF_inpcsrc       = 1'b0;
    IF_inbaddress    = 32'h0;
    IF_injump        = 2'b00;
    IF_injumpaddress = 32'h0;
    IF_inrjump       = 2'b00;
    IF_injraddress   = 32'h0;
  endtask

  // Entered at a falling edge with the FSM in REQ; waits, then pulses ack for one cycle.
  task automatic do_fetch(input logic [31:0] word, input int wait_n, input logic [31:0] addr);
    for (int i = 0; i < wait_n; i++) begin
      check("wait_req", {31'h0, IMEM_req}, 32'h1);
      check("wait_addr", IMEM_addr, addr);
      check("wait_order", IFID_ORDER, cur_order);
      check("wait_valid", {31'h0, IFID_VALID}, {31'h0, cur_valid});
      @(negedge CLOCK);
    end
    check("ack_req", {31'h0, IMEM_req}, 32'h1);
    check("ack_addr", IMEM_addr, addr);
    IMEM_ack   = 1'b1;
    IMEM_rdata = word;
    @(negedge CLOCK);
    IMEM_ack   = 1'b0;
    IMEM_rdata = BAD;
  endtask

  task automatic expect_ifid(input logic [31:0] order, input logic [31:0] add4,
                             input logic valid, input logic [31:0] next_addr);
    check("ifid_order", IFID_ORDER, order);
    check("ifid_pcadd4", IFID_PCADD4, add4);
    check("ifid_valid", {31'h0, IFID_VALID}, {31'h0, valid});
    check("next_addr", IMEM_addr, next_addr);
    check("next_pc", IF_outPC, next_addr);
    check("next_req", {31'h0, IMEM_req}, 32'h1);
    cur_order = order;
    cur_valid = valid;
    $display("txn order=%h pcadd4=%h valid=%0b next_addr=%h", IFID_ORDER, IFID_PCADD4, IFID_VALID, IMEM_addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET          = 1'b0;
    IF_inPCWRITE   = 1'b1;
    IF_inIFIDWRITE = 1'b1;
    IMEM_ack       = 1'b0;
    IMEM_rdata     = 32'h0;
    clear_redirect();
    cur_order = NOP;
    cur_valid = 1'b0;

    // reset state
    repeat (2) @(negedge CLOCK);
    check("rst_req", {31'h0, IMEM_req}, 32'h0);
    check("rst_addr", IMEM_addr, 32'h0);
    check("rst_order", IFID_ORDER, NOP);
    check("rst_pcadd4", IFID_PCADD4, 32'h0);
    check("rst_valid", {31'h0, IFID_VALID}, 32'h0);
    check("rst_pc", IF_outPC, 32'h0);

    // release with a stray ack while in IDLE
    IMEM_ack   = 1'b1;
    IMEM_rdata = BAD;
    RESET      = 1'b1;
    @(negedge CLOCK);
    IMEM_ack = 1'b0;
    check("idle_ack_req", {31'h0, IMEM_req}, 32'h1);
    check("idle_ack_addr", IMEM_addr, 32'h0);
    check("idle_ack_valid", {31'h0, IFID_VALID}, 32'h0);

    // 1: back-to-back fetches
    do_fetch(32'h1111_0000, 1, 32'h0);
    expect_ifid(32'h1111_0000, 32'h4, 1'b1, 32'h4);
    do_fetch(32'h1111_0004, 1, 32'h4);
    expect_ifid(32'h1111_0004, 32'h8, 1'b1, 32'h8);
    do_fetch(32'h1111_0008, 1, 32'h8);
    expect_ifid(32'h1111_0008, 32'hC, 1'b1, 32'hC);

    // 2: slow memory
    do_fetch(32'h1111_000C, 3, 32'hC);
    expect_ifid(32'h1111_000C, 32'h10, 1'b1, 32'h10);

    // 3: ack while stalled parks the word; stray ack in HOLD is ignored
    IF_inPCWRITE   = 1'b0;
    IF_inIFIDWRITE = 1'b0;
    IMEM_ack       = 1'b1;
    IMEM_rdata     = 32'h1000_0004;
    @(negedge CLOCK);
    IMEM_rdata = BAD;
    check("hold_req", {31'h0, IMEM_req}, 32'h0);
    check("hold_order", IFID_ORDER, 32'h1111_000C);
    @(negedge CLOCK);
    IMEM_ack = 1'b0;
    check("hold2_req", {31'h0, IMEM_req}, 32'h0);
    check("hold2_order", IFID_ORDER, 32'h1111_000C);
    check("hold2_pc", IF_outPC, 32'h10);
    IF_inPCWRITE   = 1'b1;
    IF_inIFIDWRITE = 1'b1;
    @(negedge CLOCK);
    expect_ifid(32'h1000_0004, 32'h14, 1'b1, 32'h14);

    // 4: beq at 0x10 in IF/ID; redirect seen before ack is pended
    IF_inpcsrc    = 1'b1;
    IF_inbaddress = 32'h40;
    @(negedge CLOCK);
    check("pend_addr", IMEM_addr, 32'h14);
    check("pend_order", IFID_ORDER, 32'h1000_0004);
    clear_redirect();
    IMEM_ack   = 1'b1;
    IMEM_rdata = 32'h2222_0014;
    @(negedge CLOCK);
    IMEM_ack   = 1'b0;
    IMEM_rdata = BAD;
`ifdef IFID_FLUSH_EN
    expect_ifid(NOP, 32'h18, 1'b0, 32'h40);
`else
    expect_ifid(32'h2222_0014, 32'h18, 1'b1, 32'h40);
`endif

    // 5: jr beats a taken branch
    do_fetch(32'h3333_0040, 0, 32'h40);
    expect_ifid(32'h3333_0040, 32'h44, 1'b1, 32'h44);
    IF_inrjump     = 2'b01;
    IF_injraddress = 32'h80;
    IF_inpcsrc     = 1'b1;
    IF_inbaddress  = 32'h40;
    do_fetch(32'h3333_0044, 0, 32'h44);
    clear_redirect();
`ifdef IFID_FLUSH_EN
    expect_ifid(NOP, 32'h48, 1'b0, 32'h80);
`else
    expect_ifid(32'h3333_0044, 32'h48, 1'b1, 32'h80);
`endif

    // j beats a taken branch
    do_fetch(32'h4444_0080, 0, 32'h80);
    expect_ifid(32'h4444_0080, 32'h84, 1'b1, 32'h84);
    IF_injump        = 2'b01;
    IF_injumpaddress = 32'h100;
    IF_inpcsrc       = 1'b1;
    IF_inbaddress    = 32'h40;
    do_fetch(32'h4444_0084, 0, 32'h84);
    clear_redirect();
`ifdef IFID_FLUSH_EN
    expect_ifid(NOP, 32'h88, 1'b0, 32'h100);
`else
    expect_ifid(32'h4444_0084, 32'h88, 1'b1, 32'h100);
`endif

    // jr to the top word, then PC+4 wraps to zero
    do_fetch(32'h5555_0100, 0, 32'h100);
    expect_ifid(32'h5555_0100, 32'h104, 1'b1, 32'h104);
    IF_injump      = 2'b10;
    IF_injraddress = 32'hFFFF_FFFC;
    do_fetch(32'h5555_0104, 0, 32'h104);
    clear_redirect();
`ifdef IFID_FLUSH_EN
    expect_ifid(NOP, 32'h108, 1'b0, 32'hFFFF_FFFC);
`else
    expect_ifid(32'h5555_0104, 32'h108, 1'b1, 32'hFFFF_FFFC);
`endif
    do_fetch(32'h6666_FFFC, 0, 32'hFFFF_FFFC);
    expect_ifid(32'h6666_FFFC, 32'h0, 1'b1, 32'h0);

    // 6: reset mid-REQ with ack arriving during reset
    IMEM_ack   = 1'b1;
    IMEM_rdata = BAD;
    RESET      = 1'b0;
    #1;
    check("mid_rst_req", {31'h0, IMEM_req}, 32'h0);
    check("mid_rst_valid", {31'h0, IFID_VALID}, 32'h0);
    check("mid_rst_order", IFID_ORDER, NOP);
    check("mid_rst_pcadd4", IFID_PCADD4, 32'h0);
    check("mid_rst_pc", IF_outPC, 32'h0);
    @(negedge CLOCK);
    check("in_rst_req", {31'h0, IMEM_req}, 32'h0);
    RESET = 1'b1;
    @(negedge CLOCK);
    IMEM_ack = 1'b0;
    check("restart_req", {31'h0, IMEM_req}, 32'h1);
    check("restart_addr", IMEM_addr, 32'h0);
    check("restart_valid", {31'h0, IFID_VALID}, 32'h0);
    cur_order = NOP;
    cur_valid = 1'b0;
    do_fetch(32'h7777_0000, 1, 32'h0);
    expect_ifid(32'h7777_0000, 32'h4, 1'b1, 32'h4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
